// File: rtl/pc.sv
// ---------------------------------------------------------------------------
// pc -- program counter register
//
// Holds the address of the current instruction. When enable is high, the
// value on next_pc is captured on the rising clock edge. When enable is low,
// the value is held. An asynchronous, active-high reset forces RESET_ADDR
// immediately, and reset takes priority over enable.
//
// Parameters:
//   XLEN        width of the program counter and address datapath (>= 2)
//   RESET_ADDR  value held while reset is asserted
//
// Ports:
//   clk         input   1     rising-edge clock
//   reset       input   1     asynchronous reset, active high
//   enable      input   1     1 = load next_pc on the next edge, 0 = hold
//   next_pc     input   XLEN  candidate address for the next instruction
//   curr_pc     output  XLEN  registered current program counter
//   misaligned  output  1     high when curr_pc[1:0] != 2'b00
// ---------------------------------------------------------------------------
module pc #(
  parameter int unsigned         XLEN       = 32,
  parameter logic [XLEN-1:0]     RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] curr_pc,
  output logic            misaligned
);

  // curr_pc is the register output itself, so there is no combinational
  // path from next_pc to curr_pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curr_pc <= RESET_ADDR;
    end else if (enable) begin
      curr_pc <= next_pc;
    end
  end

  // misaligned depends only on the registered value. It is a status flag
  // and has no effect on loading.
  assign misaligned = |curr_pc[1:0];

endmodule

// File: tb/tb_pc.sv
// ---------------------------------------------------------------------------
// tb_pc -- self-checking bench for pc.
//
// The directed tasks follow a fixed timeline (clock period 10, rising edges
// at 5, 15, 25, ...). A randomized phase then compares the DUT against a
// behavioural model in which reset forces RESET_ADDR, an edge with enable
// high loads next_pc, and an edge with enable low holds the value.
// ---------------------------------------------------------------------------
module tb_pc;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] curr_pc;
  logic            misaligned;

  int n_cmp;
  int n_err;

  pc #(
    .XLEN       (XLEN),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .next_pc    (next_pc),
    .curr_pc    (curr_pc),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t=0 .. t=20
  task automatic test_reset();
    #1;  // t=1
    n_cmp++;
    if (curr_pc !== RESET_ADDR) begin
      n_err++;
      $display("FAIL reset_t1: curr_pc=%h expected %h", curr_pc, RESET_ADDR);
    end
    n_cmp++;
    if (misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misaligned: misaligned=%b expected 0", misaligned);
    end
    #9 reset = 1'b0;  // t=10
    #2;  // t=12
    n_cmp++;
    if (curr_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release_hold: curr_pc=%h expected 0", curr_pc);
    end
    #8;  // t=20
  endtask

  // t=20 .. t=60
  task automatic test_load_hold();
    enable  = 1'b1;
    next_pc = 32'h4;
    #6;  // t=26
    n_cmp++;
    if (curr_pc !== 32'h4) begin
      n_err++;
      $display("FAIL load_4: curr_pc=%h expected 00000004", curr_pc);
    end
    #4 next_pc = 32'h8;  // t=30
    #6;  // t=36
    n_cmp++;
    if (curr_pc !== 32'h8) begin
      n_err++;
      $display("FAIL load_8: curr_pc=%h expected 00000008", curr_pc);
    end
    #4 enable = 1'b0;  // t=40
    #6;  // t=46
    n_cmp++;
    if (curr_pc !== 32'h8) begin
      n_err++;
      $display("FAIL hold_45: curr_pc=%h expected 00000008", curr_pc);
    end
    #4 next_pc = 32'hC;  // t=50
    #6;  // t=56
    n_cmp++;
    if (curr_pc !== 32'h8) begin
      n_err++;
      $display("FAIL hold_55: curr_pc=%h expected 00000008", curr_pc);
    end
    #4;  // t=60
  endtask

  // t=60 .. t=86
  task automatic test_async_reset();
    enable  = 1'b1;
    next_pc = 32'h1234;
    #2 reset = 1'b1;  // t=62, between edges
    #1;  // t=63, before edge at 65
    n_cmp++;
    if (curr_pc !== RESET_ADDR) begin
      n_err++;
      $display("FAIL async_reset_immediate: curr_pc=%h expected %h", curr_pc, RESET_ADDR);
    end
    n_cmp++;
    if (misaligned !== (RESET_ADDR[1:0] != 2'b00)) begin
      n_err++;
      $display("FAIL async_reset_misaligned: misaligned=%b", misaligned);
    end
    #3;  // t=66
    n_cmp++;
    if (curr_pc !== RESET_ADDR) begin
      n_err++;
      $display("FAIL reset_dominates_65: curr_pc=%h expected %h", curr_pc, RESET_ADDR);
    end
    #10;  // t=76
    n_cmp++;
    if (curr_pc !== RESET_ADDR) begin
      n_err++;
      $display("FAIL reset_dominates_75: curr_pc=%h expected %h", curr_pc, RESET_ADDR);
    end
    #4 reset = 1'b0;  // t=80
    #6;  // t=86
    n_cmp++;
    if (curr_pc !== 32'h1234) begin
      n_err++;
      $display("FAIL first_load_after_reset: curr_pc=%h expected 00001234", curr_pc);
    end
  endtask

  // t=86 onward; each step waits one edge
  task automatic test_boundary();
    enable  = 1'b1;
    next_pc = 32'hFFFF_FFFF;
    #10;  // t=96
    n_cmp++;
    if (curr_pc !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL all_ones_load: curr_pc=%h expected ffffffff", curr_pc);
    end
    n_cmp++;
    if (misaligned !== 1'b1) begin
      n_err++;
      $display("FAIL all_ones_misaligned: misaligned=%b expected 1", misaligned);
    end
    enable  = 1'b0;
    next_pc = 32'h0;
    #10;
    n_cmp++;
    if (curr_pc !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL all_ones_hold: curr_pc=%h expected ffffffff", curr_pc);
    end
    enable  = 1'b1;
    next_pc = 32'hFFFF_FFFC;
    #10;
    n_cmp++;
    if (curr_pc !== 32'hFFFF_FFFC || misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL fffffffc_load: curr_pc=%h mis=%b expected fffffffc mis=0", curr_pc, misaligned);
    end
    next_pc = 32'h0000_0002;
    #10;
    n_cmp++;
    if (curr_pc !== 32'h2 || misaligned !== 1'b1) begin
      n_err++;
      $display("FAIL low_bits_verbatim: curr_pc=%h mis=%b expected 00000002 mis=1", curr_pc, misaligned);
    end
    next_pc = 32'h10;
    #10;
    n_cmp++;
    if (curr_pc !== 32'h10 || misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL load_10: curr_pc=%h mis=%b expected 00000010 mis=0", curr_pc, misaligned);
    end
  endtask

  task automatic test_random(input int unsigned cycles);
    logic [XLEN-1:0] model_pc;
    logic            model_mis;
    int unsigned     errs_here;
    model_pc  = curr_pc;  // directed phase left a checked value behind
    model_pc  = 32'h10;
    errs_here = 0;
    @(negedge clk);
    for (int unsigned i = 0; i < cycles; i++) begin
      // Inputs change at the falling edge, well away from the rising edge.
      enable  = ($urandom_range(0, 2) != 0);
      next_pc = $urandom();
      if ($urandom_range(0, 3) == 0) next_pc[1:0] = 2'b00;
      if ($urandom_range(0, 24) == 0) begin
        #2 reset = 1'b1;
        model_pc = RESET_ADDR;
        #1;
        n_cmp++;
        if (curr_pc !== model_pc) begin
          n_err++;
          errs_here++;
          if (errs_here <= 10)
            $display("FAIL rand_async_reset[%0d]: curr_pc=%h expected %h", i, curr_pc, model_pc);
        end
      end else begin
        reset = 1'b0;
      end
      @(posedge clk);
      if (!reset && enable) model_pc = next_pc;
      #1;
      // Perturb inputs between edges; they must not matter until next edge.
      next_pc = $urandom();
      enable  = $urandom_range(0, 1) != 0;
      model_mis = (model_pc % 4) != 0;
      n_cmp++;
      if (curr_pc !== model_pc || misaligned !== model_mis) begin
        n_err++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL rand_cycle[%0d]: curr_pc=%h mis=%b expected %h mis=%b",
                   i, curr_pc, misaligned, model_pc, model_mis);
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    next_pc = '0;
    test_reset();
    test_load_hold();
    test_async_reset();
    test_boundary();
    test_random(12000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
